// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Multicycle control FSM for an RV32I core. Walks each instruction
//            through FETCH, DECODE, EXEC, MEM and WB and drives the datapath
//            selects, register-file write, memory handshakes and PC load.
//            Illegal instructions park the FSM in a sticky TRAP state.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports    : clk, rst        clock, synchronous active-high reset
//            inst[XLEN]      instruction word, valid while imem_ready=1
//            imem_ready      instruction memory has data this cycle
//            dmem_ready      data memory access completes this cycle
//            br_eq, br_lt    branch comparator results
//            imem_req        instruction fetch request
//            IRWrite         instruction register load enable
//            ImmSel[3]       0=I/load/JALR 1=S 2=B 3=U 4=JAL
//            ASel, BSel      ALU operand selects (PC / immediate)
//            alu_op[2]       0=add 1=funct decode 2=pass B
//            BrUn            unsigned branch compare
//            dmem_req/we     data memory request / write
//            RegWEn          register-file write enable
//            WBSel[2]        0=mem 1=ALU 2=PC+4
//            PCWrite, PCSel  PC load enable, 0=PC+4 1=ALU result
//            trap            illegal instruction, sticky until rst
//            instret[XLEN]   retired-instruction count
// Options  : IMMGEN_UTYPE_EN - when defined, LUI and AUIPC are executed;
//            otherwise both opcodes are illegal.
// ============================================================================
module multicycle_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] inst,
  input  logic            imem_ready,
  input  logic            dmem_ready,
  input  logic            br_eq,
  input  logic            br_lt,
  output logic            imem_req,
  output logic            IRWrite,
  output logic [2:0]      ImmSel,
  output logic            ASel,
  output logic            BSel,
  output logic [1:0]      alu_op,
  output logic            BrUn,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic            RegWEn,
  output logic [1:0]      WBSel,
  output logic            PCWrite,
  output logic            PCSel,
  output logic            trap,
  output logic [XLEN-1:0] instret
);

`ifdef IMMGEN_UTYPE_EN
  localparam logic UTYPE_EN = 1'b1;
`else
  localparam logic UTYPE_EN = 1'b0;
`endif

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t     state;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7b5;

  // Instruction class decode from the latched opcode
  logic is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr;
  logic is_lui, is_auipc, is_jump, legal;

  assign is_r      = (opcode == OP_R);
  assign is_i      = (opcode == OP_I);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign is_lui    = UTYPE_EN && (opcode == OP_LUI);
  assign is_auipc  = UTYPE_EN && (opcode == OP_AUIPC);
  assign is_jump   = is_jal | is_jalr;
  // Branch funct3 010/011 are unassigned encodings
  assign legal     = is_r | is_i | is_load | is_store | is_jal | is_jalr |
                     is_lui | is_auipc | (is_branch && (funct3[2:1] != 2'b01));

  // funct7[5] is latched for the ALU decoder downstream; the remaining
  // instruction bits are not needed by the controller.
  logic unused_fields;
  assign unused_fields = ^{f7b5, inst[XLEN-1:31], inst[29:15], inst[11:7]};

  logic [2:0] imm_sel;
  logic       ex_asel, ex_bsel;
  logic [1:0] ex_alu_op;
  logic       br_taken;

  always_comb begin
    imm_sel   = 3'd0;
    ex_asel   = 1'b0;
    ex_bsel   = 1'b1;
    ex_alu_op = 2'd0;
    if (is_store)             imm_sel = 3'd1;
    else if (is_branch)       imm_sel = 3'd2;
    else if (is_lui|is_auipc) imm_sel = 3'd3;
    else if (is_jal)          imm_sel = 3'd4;

    if (is_r) begin
      ex_bsel   = 1'b0;
      ex_alu_op = 2'd1;
    end else if (is_i) begin
      ex_alu_op = 2'd1;
    end else if (is_lui) begin
      ex_alu_op = 2'd2;
    end else if (is_jal | is_branch | is_auipc) begin
      ex_asel   = 1'b1;
    end
  end

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:         br_taken = br_eq;
      3'b001:         br_taken = ~br_eq;
      3'b100, 3'b110: br_taken = br_lt;
      3'b101, 3'b111: br_taken = ~br_lt;
      default:        br_taken = 1'b0;
    endcase
  end

  // Outputs are a function of state and latched fields; reset forces all low
  // so nothing leaks out of an interrupted MEM or WB cycle.
  always_comb begin
    imem_req = 1'b0;
    IRWrite  = 1'b0;
    ImmSel   = 3'd0;
    ASel     = 1'b0;
    BSel     = 1'b0;
    alu_op   = 2'd0;
    BrUn     = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    RegWEn   = 1'b0;
    WBSel    = 2'd0;
    PCWrite  = 1'b0;
    PCSel    = 1'b0;
    trap     = 1'b0;
    if (!rst) begin
      if (state == S_DECODE || state == S_EXEC || state == S_MEM || state == S_WB)
        ImmSel = imm_sel;
      // ALU selects from EXEC stay up while the address / link value is used
      if (state == S_EXEC || state == S_MEM || (state == S_WB && is_jump)) begin
        ASel   = ex_asel;
        BSel   = ex_bsel;
        alu_op = ex_alu_op;
      end
      case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          IRWrite  = imem_ready;
        end
        S_EXEC: begin
          if (is_branch) begin
            BrUn    = funct3[1];
            PCWrite = 1'b1;
            PCSel   = br_taken;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = is_store;
          PCWrite  = is_store & dmem_ready;
        end
        S_WB: begin
          RegWEn  = 1'b1;
          PCWrite = 1'b1;
          if (is_load) begin
            WBSel = 2'd0;
          end else if (is_jump) begin
            WBSel = 2'd2;
            PCSel = 1'b1;
          end else begin
            WBSel = 2'd1;
          end
        end
        S_TRAP:  trap = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      opcode  <= 7'd0;
      funct3  <= 3'd0;
      f7b5    <= 1'b0;
      instret <= '0;
    end else begin
      if (PCWrite)
        instret <= instret + {{(XLEN-1){1'b0}}, 1'b1};
      case (state)
        S_FETCH: begin
          if (imem_ready) begin
            opcode <= inst[6:0];
            funct3 <= inst[14:12];
            f7b5   <= inst[30];
            state  <= S_DECODE;
          end
        end
        S_DECODE: state <= legal ? S_EXEC : S_TRAP;
        S_EXEC: begin
          if (is_branch)                state <= S_FETCH;
          else if (is_load || is_store) state <= S_MEM;
          else                          state <= S_WB;
        end
        S_MEM: begin
          if (dmem_ready) state <= is_load ? S_WB : S_FETCH;
        end
        S_WB:    state <= S_FETCH;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Purpose  : Self-checking bench for multicycle_ctrl. A per-instruction step
//            model predicts every output each cycle; directed instruction
//            vectors also check hand-computed values at known cycles.
// Revision : 1.0 - initial release
// Options  : IMMGEN_UTYPE_EN - must match the build of the design.
// ============================================================================
module tb_multicycle_ctrl;

  logic        clk, rst;
  logic [31:0] inst;
  logic        imem_ready, dmem_ready, br_eq, br_lt;
  logic        imem_req, IRWrite, ASel, BSel, BrUn, dmem_req, dmem_we;
  logic        RegWEn, PCWrite, PCSel, trap;
  logic [2:0]  ImmSel;
  logic [1:0]  alu_op, WBSel;
  logic [31:0] instret;

  multicycle_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .inst(inst), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .br_eq(br_eq), .br_lt(br_lt),
    .imem_req(imem_req), .IRWrite(IRWrite), .ImmSel(ImmSel), .ASel(ASel),
    .BSel(BSel), .alu_op(alu_op), .BrUn(BrUn), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .RegWEn(RegWEn), .WBSel(WBSel), .PCWrite(PCWrite),
    .PCSel(PCSel), .trap(trap), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       imem_req;
    logic       irw;
    logic [2:0] imm;
    logic       asel;
    logic       bsel;
    logic [1:0] alu;
    logic       brun;
    logic       dreq;
    logic       dwe;
    logic       regw;
    logic [1:0] wbsel;
    logic       pcw;
    logic       pcsel;
    logic       trap;
  } outs_t;

  outs_t obs;
  assign obs = {imem_req, IRWrite, ImmSel, ASel, BSel, alu_op, BrUn, dmem_req,
                dmem_we, RegWEn, WBSel, PCWrite, PCSel, trap};

  int vectors = 0;
  int fails   = 0;

  // ---------------- behavioural model ----------------
  localparam int C_R = 0, C_I = 1, C_LD = 2, C_ST = 3, C_BR = 4, C_JAL = 5,
                 C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_ILL = 9;

  function automatic int cls_of(input logic [31:0] w);
    case (w[6:0])
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b0000011: return C_LD;
      7'b0100011: return C_ST;
      7'b1100011: return (w[14:13] == 2'b01) ? C_ILL : C_BR;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
`ifdef IMMGEN_UTYPE_EN
      7'b0110111: return C_LUI;
      7'b0010111: return C_AUIPC;
`endif
      default:    return C_ILL;
    endcase
  endfunction

  function automatic logic [2:0] imm_of(input logic [31:0] w);
    case (w[6:0])
      7'b0100011: return 3'd1;
      7'b1100011: return 3'd2;
      7'b1101111: return 3'd4;
`ifdef IMMGEN_UTYPE_EN
      7'b0110111, 7'b0010111: return 3'd3;
`endif
      default:    return 3'd0;
    endcase
  endfunction

  // Cycles from fetch to retirement with both memories ready
  function automatic int lat_of(input int c);
    if (c == C_BR) return 3;
    if (c == C_LD) return 5;
    return 4;
  endfunction

  function automatic bit is_mem(input int c);
    return (c == C_LD) || (c == C_ST);
  endfunction

  // {ASel, BSel, alu_op} while executing
  function automatic logic [3:0] exsel_of(input int c);
    case (c)
      C_R:     return {1'b0, 1'b0, 2'd1};
      C_I:     return {1'b0, 1'b1, 2'd1};
      C_LUI:   return {1'b0, 1'b1, 2'd2};
      C_JAL, C_BR, C_AUIPC: return {1'b1, 1'b1, 2'd0};
      default: return {1'b0, 1'b1, 2'd0};
    endcase
  endfunction

  function automatic logic taken_of(input logic [2:0] f3, input logic eq, input logic lt);
    if (f3 == 3'b000) return eq;
    if (f3 == 3'b001) return !eq;
    if (f3[2] && !f3[0]) return lt;
    if (f3[2] && f3[0])  return !lt;
    return 1'b0;
  endfunction

  int          m_step = 1;
  bit          m_trap = 1'b0;
  logic [31:0] m_word = 32'd0;
  logic [31:0] m_instret = 32'd0;
  outs_t       m_e;
  int          m_c;

  function automatic outs_t model_out();
    outs_t e = '0;
    int c = cls_of(m_word);
    if (rst) return e;
    if (m_trap) begin
      e.trap = 1'b1;
      return e;
    end
    if (m_step == 1) begin
      e.imem_req = 1'b1;
      e.irw      = imem_ready;
      return e;
    end
    e.imm = imm_of(m_word);
    if (m_step == 3 || (m_step == 4 && (is_mem(c) || c == C_JAL || c == C_JALR)))
      {e.asel, e.bsel, e.alu} = exsel_of(c);
    if (m_step == 3 && c == C_BR) begin
      e.brun  = m_word[13];
      e.pcw   = 1'b1;
      e.pcsel = taken_of(m_word[14:12], br_eq, br_lt);
    end
    if (m_step == 4 && is_mem(c)) begin
      e.dreq = 1'b1;
      e.dwe  = (c == C_ST);
      e.pcw  = (c == C_ST) && dmem_ready;
    end
    if (m_step == lat_of(c) && c != C_BR && c != C_ST) begin
      e.regw  = 1'b1;
      e.pcw   = 1'b1;
      e.wbsel = (c == C_LD) ? 2'd0 : (c == C_JAL || c == C_JALR) ? 2'd2 : 2'd1;
      e.pcsel = (c == C_JAL || c == C_JALR);
    end
    return e;
  endfunction

  always @(posedge clk) begin
    m_e = model_out();
    if (rst) begin
      m_step = 1; m_trap = 1'b0; m_instret = 32'd0; m_word = 32'd0;
    end else if (!m_trap) begin
      m_c = cls_of(m_word);
      if (m_e.pcw) m_instret = m_instret + 32'd1;
      if (m_step == 1) begin
        if (imem_ready) begin
          m_word = inst;
          m_step = 2;
        end
      end else if (m_step == 2 && m_c == C_ILL) begin
        m_trap = 1'b1;
      end else if (!(m_step == 4 && is_mem(m_c) && !dmem_ready)) begin
        m_step = (m_step == lat_of(m_c)) ? 1 : m_step + 1;
      end
    end
  end

  // Every-cycle comparison against the model, mid-cycle
  outs_t exp_o;
  always @(negedge clk) begin
    exp_o = model_out();
    vectors++;
    if (obs !== exp_o) begin
      fails++;
      $display("FAIL outputs t=%0t: got %h expected %h", $time, obs, exp_o);
    end
    vectors++;
    if (instret !== m_instret) begin
      fails++;
      $display("FAIL instret t=%0t: got %0d expected %0d", $time, instret, m_instret);
    end
  end

  // ---------------- directed stimulus ----------------
  outs_t rec [1:16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  localparam int F_DREQ = 0, F_DWE = 1, F_PCW = 2, F_REGW = 3, F_TRAP = 4;

  function automatic int count_of(input int which, input int n);
    int k = 0;
    for (int c = 1; c <= n; c++) begin
      case (which)
        F_DREQ:  k += int'(rec[c].dreq);
        F_DWE:   k += int'(rec[c].dwe);
        F_PCW:   k += int'(rec[c].pcw);
        F_REGW:  k += int'(rec[c].regw);
        default: k += int'(rec[c].trap);
      endcase
    end
    return k;
  endfunction

  // Starts at a drive point with the DUT in FETCH; runs n cycles, recording
  // outputs mid-cycle. Readies are held low for the first cycles so they are
  // also seen outside their own state.
  task automatic run(input logic [31:0] w, input logic eq, input logic lt,
                     input int istall, input int dstall, input int n);
    inst  = w;
    br_eq = eq;
    br_lt = lt;
    for (int c = 1; c <= n; c++) begin
      imem_ready = (c > istall);
      dmem_ready = (c > 3 + istall + dstall);
      @(negedge clk);
      rec[c] = obs;
      @(posedge clk); #1;
    end
  endtask

  localparam logic [31:0] ADDI = 32'h00500093, SW   = 32'h0020A023,
                          BEQ  = 32'h00208463, JAL  = 32'h008000EF,
                          BLT  = 32'h0020C463, BGEU = 32'h0020F463,
                          LW   = 32'h0000A103, ADD  = 32'h002081B3,
                          LUI  = 32'h000002B7, BILL = 32'h0020A463;

  initial begin
    rst = 1'b1; inst = 32'd0; imem_ready = 1'b1; dmem_ready = 1'b1;
    br_eq = 1'b0; br_lt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(obs), 32'd0);
    chk("reset_instret", instret, 32'd0);
    rst = 1'b0;

    run(ADDI, 0, 0, 0, 0, 4);
    chk("addi_immsel", 32'(rec[3].imm), 32'd0);
    chk("addi_bsel", 32'(rec[3].bsel), 32'd1);
    chk("addi_regw_c4", 32'(rec[4].regw), 32'd1);
    chk("addi_pcw_c4", 32'(rec[4].pcw), 32'd1);
    chk("addi_instret", instret, 32'd1);

    run(SW, 0, 0, 0, 3, 7);
    chk("sw_dreq_cycles", count_of(F_DREQ, 7), 32'd4);
    chk("sw_dwe_cycles", count_of(F_DWE, 7), 32'd4);
    chk("sw_immsel", 32'(rec[5].imm), 32'd1);
    chk("sw_pcw_count", count_of(F_PCW, 7), 32'd1);
    chk("sw_pcw_ready", 32'(rec[7].pcw), 32'd1);
    chk("sw_regw_none", count_of(F_REGW, 7), 32'd0);
    chk("sw_instret", instret, 32'd2);

    run(BEQ, 1, 0, 0, 0, 3);
    chk("beq_t_immsel", 32'(rec[3].imm), 32'd2);
    chk("beq_t_pcw_c3", 32'(rec[3].pcw), 32'd1);
    chk("beq_t_pcsel", 32'(rec[3].pcsel), 32'd1);
    run(BEQ, 0, 0, 0, 0, 3);
    chk("beq_nt_pcsel", 32'(rec[3].pcsel), 32'd0);
    chk("beq_instret", instret, 32'd4);

    run(JAL, 0, 0, 0, 0, 4);
    chk("jal_immsel", 32'(rec[4].imm), 32'd4);
    chk("jal_wbsel", 32'(rec[4].wbsel), 32'd2);
    chk("jal_pcsel", 32'(rec[4].pcsel), 32'd1);
    chk("jal_asel_wb", 32'(rec[4].asel), 32'd1);

    run(BLT, 0, 1, 0, 0, 3);
    chk("blt_pcsel", 32'(rec[3].pcsel), 32'd1);
    chk("blt_brun", 32'(rec[3].brun), 32'd0);
    run(BGEU, 0, 1, 0, 0, 3);
    chk("bgeu_pcsel", 32'(rec[3].pcsel), 32'd0);
    chk("bgeu_brun", 32'(rec[3].brun), 32'd1);

    run(LW, 0, 0, 0, 0, 5);
    chk("lw_dwe", 32'(rec[4].dwe), 32'd0);
    chk("lw_regw_c5", 32'(rec[5].regw), 32'd1);
    chk("lw_wbsel", 32'(rec[5].wbsel), 32'd0);
    chk("lw_instret", instret, 32'd8);

    // Reset while a load waits in MEM
    run(LW, 0, 0, 0, 10, 4);
    chk("lwrst_dreq_mem", 32'(rec[4].dreq), 32'd1);
    rst = 1'b1;
    dmem_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    imem_ready = 1'b0;
    @(negedge clk);
    chk("lwrst_dreq_after", 32'(dmem_req), 32'd0);
    chk("lwrst_regw_after", 32'(RegWEn), 32'd0);
    chk("lwrst_fetch", 32'(imem_req), 32'd1);
    chk("lwrst_instret", instret, 32'd0);
    @(posedge clk); #1;

    run(ADD, 0, 0, 2, 0, 6);
    chk("add_irw_stall", 32'(rec[1].irw), 32'd0);
    chk("add_irw_ready", 32'(rec[3].irw), 32'd1);
    chk("add_alu_op", 32'(rec[5].alu), 32'd1);
    chk("add_instret", instret, 32'd1);

`ifdef IMMGEN_UTYPE_EN
    run(LUI, 0, 0, 0, 0, 4);
    chk("lui_immsel", 32'(rec[3].imm), 32'd3);
    chk("lui_alu_op", 32'(rec[3].alu), 32'd2);
    chk("lui_wbsel", 32'(rec[4].wbsel), 32'd1);
    chk("lui_instret", instret, 32'd2);
`else
    run(LUI, 0, 0, 0, 0, 6);
    chk("lui_trap_cycles", count_of(F_TRAP, 6), 32'd4);
    chk("lui_no_pcw", count_of(F_PCW, 6), 32'd0);
    chk("lui_instret", instret, 32'd1);
`endif

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    run(BILL, 1, 0, 0, 0, 4);
    chk("bill_decode_imm", 32'(rec[2].imm), 32'd2);
    chk("bill_trap", count_of(F_TRAP, 4), 32'd2);
    chk("bill_instret", instret, 32'd0);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    imem_ready = 1'b0;
    @(negedge clk);
    chk("trap_cleared", 32'(trap), 32'd0);
    chk("trap_refetch", 32'(imem_req), 32'd1);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete within the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle control FSM for the RV32I core; sequences fetch, decode, execute, memory and writeback over several clocks.
- Drives ImmSel into the immediate generator, plus mux selects, register-file write and memory handshakes.
- Latches opcode, funct3 and funct7[5] on instruction fetch.
- Asserts PC write exactly once per retired instruction.

Parameters:
- XLEN, 32, width of the inst input and of the instret counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- inst  in  XLEN  instruction word from instruction memory; valid when imem_ready=1.
- imem_ready  in  1  instruction memory has data this cycle.
- dmem_ready  in  1  data memory has completed the access this cycle.
- br_eq  in  1  rs1==rs2 from the branch comparator.
- br_lt  in  1  rs1<rs2 from the branch comparator; signedness set by BrUn.
- imem_req  out  1  instruction fetch request.
- IRWrite  out  1  instruction register load enable.
- ImmSel  out  3  0=I/load/JALR, 1=S, 2=B, 3=U, 4=JAL.
- ASel  out  1  0=rs1, 1=PC.
- BSel  out  1  0=rs2, 1=imm.
- alu_op  out  2  0=add, 1=funct decode, 2=pass B.
- BrUn  out  1  unsigned compare.
- dmem_req  out  1  data memory access request.
- dmem_we  out  1  data memory write (store).
- RegWEn  out  1  register-file write enable.
- WBSel  out  2  0=mem, 1=ALU, 2=PC+4.
- PCWrite  out  1  PC load enable.
- PCSel  out  1  0=PC+4, 1=ALU result.
- trap  out  1  illegal instruction, sticky.
- instret  out  XLEN  retired-instruction count.

Behaviour:
- Reset: rst is synchronous and active-high. While rst=1 on a clock edge: state<=FETCH, latched fields<=0, instret<=0, trap<=0.
- Outputs are combinational from state and latched fields. Every output is 0 in the reset cycle and in any state where it is not listed below.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- FETCH:
  - imem_req=1.
  - Hold while imem_ready=0.
  - On imem_ready=1: IRWrite=1, latch opcode=inst[6:0], funct3=inst[14:12], f7b5=inst[30]; go to DECODE.
- DECODE:
  - ImmSel driven from the latched opcode.
  - Illegal opcode, or BRANCH with funct3 010/011 -> TRAP.
  - Otherwise -> EXEC.
- EXEC:
  - R: alu_op=1, BSel=0 -> WB.
  - I-ALU: alu_op=1, BSel=1 -> WB.
  - LOAD/STORE: alu_op=0, BSel=1 -> MEM.
  - JAL: ASel=1, BSel=1, alu_op=0 -> WB.
  - JALR: ASel=0, BSel=1, alu_op=0 -> WB.
  - BRANCH: ASel=1, BSel=1, alu_op=0, BrUn=funct3[1].
    - Taken: 000 br_eq; 001 !br_eq; 100/110 br_lt; 101/111 !br_lt.
    - PCWrite=1, PCSel=taken -> FETCH.
- MEM:
  - dmem_req=1, dmem_we=(STORE). ALU selects from EXEC are held.
  - Hold while dmem_ready=0.
  - On dmem_ready: LOAD -> WB; STORE -> PCWrite=1, PCSel=0 -> FETCH.
- WB:
  - RegWEn=1, PCWrite=1. Then -> FETCH.
  - LOAD: WBSel=0, PCSel=0.
  - R/I: WBSel=1, PCSel=0.
  - JAL/JALR: WBSel=2, PCSel=1; ALU selects from EXEC are held.
- TRAP: trap=1. Holds all other outputs at 0 until rst.
- instret: increments by 1 in every cycle with PCWrite=1; wraps 2^XLEN-1 -> 0.
- ImmSel is stable from DECODE until leaving the instruction's last state. It is 0 for R-type.
- Minimum latency in cycles (imem_ready/dmem_ready tied high):
  - branch 3.
  - store, R, I, JAL, JALR 4.
  - load 5.
- Boundaries:
  - imem_ready outside FETCH is ignored.
  - dmem_ready outside MEM is ignored.
  - rst in MEM drops dmem_req the next cycle; no RegWEn, no PCWrite.
  - rst overrides everything, including TRAP.

Optional Feature:
- IMMGEN_UTYPE_EN defined:
  - LUI: ImmSel=3, BSel=1, alu_op=2, WBSel=1 -> WB.
  - AUIPC: ImmSel=3, ASel=1, BSel=1, alu_op=0, WBSel=1 -> WB.
- Undefined: opcodes 0110111 and 0010111 are illegal -> TRAP. ImmSel value 3 is never driven.

Test Plan:
- Reset, ready signals high, inst=0x00500093 (addi x1,x0,5) -> ImmSel=0, BSel=1; RegWEn and PCWrite in cycle 4; instret=1.
- inst=0x0020A023 (sw), dmem_ready low 3 cycles -> dmem_req=1 and dmem_we=1 held 4 cycles, ImmSel=1; PCWrite only on the ready cycle; RegWEn never asserted.
- inst=0x00208463 (beq), br_eq=1 then repeat with br_eq=0 -> ImmSel=2; PCWrite in cycle 3; PCSel=1 then 0.
- inst=0x008000EF (jal) -> ImmSel=4, WBSel=2, PCSel=1 in WB.
- inst=0x000002B7 (lui):
  - With IMMGEN_UTYPE_EN: ImmSel=3, alu_op=2.
  - Without: trap=1 after DECODE, sticky until rst; instret unchanged.
- rst asserted during MEM of lw (0x0000A103) -> next cycle state FETCH, dmem_req=0; no RegWEn; instret=0.
